// File: rtl/led_sequencer.sv
// -----------------------------------------------------------------------------
// led_sequencer
//
// LED pattern generator for board bring-up. A programmable prescaler turns
// enabled clock cycles into step events; each step advances an LED_W-bit
// pattern in one of four modes (rotate left, rotate right, bounce, binary
// count). A free-running cycle counter is driven onto the GPIO header so the
// board clock can be checked with a scope or logic analyser.
//
// Ports:
//   clk     in   1       board clock, all state updates on its rising edge
//   rst     in   1       asynchronous active-low reset (0 = reset)
//   enable  in   1       1 = prescaler runs and pattern advances, 0 = hold
//   div     in   DIV_W   tick period minus one (tick every div+1 enabled cycles)
//   mode    in   2       0 rotate-left, 1 rotate-right, 2 bounce, 3 count
//   led     out  LED_W   current pattern (registered)
//   tick    out  1       one-cycle strobe, high while a new led value is first shown
//   gpio    out  GPIO_W  free-running cycle counter (registered)
//
// Output strobe semantics: tick acts as a valid with no ready. It is high for
// exactly one cycle, in the same cycle the freshly stepped (or reloaded) led
// value first appears; led is stable in every cycle where tick is low. There
// is no back-pressure -- a consumer that misses the strobe misses the step.
// -----------------------------------------------------------------------------
module led_sequencer #(
    parameter int LED_W  = 8,
    parameter int DIV_W  = 27,
    parameter int GPIO_W = 27
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div,
    input  logic [1:0]        mode,
    output logic [LED_W-1:0]  led,
    output logic              tick,
    output logic [GPIO_W-1:0] gpio
);

    // Bounce direction is the only real state machine in the block.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [1:0] MODE_ROTL   = 2'd0;
    localparam logic [1:0] MODE_ROTR   = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_COUNT  = 2'd3;

    logic [DIV_W-1:0] pcount;
    dir_t             dir;
    logic [1:0]       mode_q;

    logic             step_evt;
    logic             mode_change;
    logic [LED_W-1:0] rotl;
    logic [LED_W-1:0] rotr;
    logic [LED_W-1:0] seed;
    logic [LED_W-1:0] led_nxt;
    dir_t             dir_nxt;

    // >= rather than == so that shrinking div below the current count
    // forces a step on the next enabled cycle instead of a full wrap.
    assign step_evt    = enable && (pcount >= div);
    assign mode_change = (mode != mode_q);

    // Count mode starts from zero; all single-hot modes start at the LSB.
    assign seed = (mode == MODE_COUNT) ? '0 : LED_W'(1);

    // Rotations built bit by bit so LED_W=1 needs no special-case slicing:
    // a 1-bit rotate is the identity.
    always_comb begin
        rotl = '0;
        rotr = '0;
        for (int i = 0; i < LED_W; i++) begin
            rotl[(i + 1) % LED_W] = led[i];
            rotr[i]               = led[(i + 1) % LED_W];
        end
    end

    // Pattern step for the currently latched mode. Bounce uses the rotations
    // as shifts: with a single hot bit that is not at the turning end, a
    // rotate and a shift give the same result. At an end the direction flips
    // and the bit moves back in the same step, so it never dwells.
    always_comb begin
        led_nxt = led;
        dir_nxt = dir;
        case (mode_q)
            MODE_ROTL: led_nxt = rotl;
            MODE_ROTR: led_nxt = rotr;
            MODE_BOUNCE: begin
                if (dir == DIR_UP) begin
                    if (led[LED_W-1]) begin
                        dir_nxt = DIR_DOWN;
                        led_nxt = rotr;
                    end else begin
                        led_nxt = rotl;
                    end
                end else begin
                    if (led[0]) begin
                        dir_nxt = DIR_UP;
                        led_nxt = rotl;
                    end else begin
                        led_nxt = rotr;
                    end
                end
            end
            default: led_nxt = led + LED_W'(1);
        endcase
    end

    // Free-running counter: runs whenever out of reset, ignores enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio <= '0;
        end else begin
            gpio <= gpio + GPIO_W'(1);
        end
    end

    // Prescaler, pattern, direction and latched mode. A mode change is only
    // taken at a step; that step reloads the seed instead of advancing, so a
    // mode request that reverts before the next step is never seen.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcount <= '0;
            led    <= LED_W'(1);
            dir    <= DIR_UP;
            mode_q <= MODE_ROTL;
            tick   <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (enable) begin
                if (step_evt) begin
                    pcount <= '0;
                    tick   <= 1'b1;
                    if (mode_change) begin
                        mode_q <= mode;
                        led    <= seed;
                        dir    <= DIR_UP;
                    end else begin
                        led <= led_nxt;
                        dir <= dir_nxt;
                    end
                end else begin
                    pcount <= pcount + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_sequencer
//
// Bench for led_sequencer (LED_W=8). A reference model tracks the pattern as
// an abstract position / phase / value and predicts every cycle's tick and
// gpio; each predicted step pushes the expected led onto exp_q, and a monitor
// on the falling edge pops it whenever the DUT raises tick. Directed sections
// walk the documented scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_led_sequencer;

    localparam int LED_W    = 8;
    localparam int DIV_W    = 27;
    localparam int GPIO_W   = 27;
    localparam int BOUNCE_P = 2 * (LED_W - 1);

    // ---------------- clock / reset / DUT ----------------
    logic              clk    = 1'b0;
    logic              rst    = 1'b0;
    logic              enable = 1'b0;
    logic [DIV_W-1:0]  div    = '0;
    logic [1:0]        mode   = 2'd0;
    logic [LED_W-1:0]  led;
    logic              tick;
    logic [GPIO_W-1:0] gpio;

    always #5 clk = ~clk;

    led_sequencer #(
        .LED_W (LED_W),
        .DIV_W (DIV_W),
        .GPIO_W(GPIO_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .div   (div),
        .mode  (mode),
        .led   (led),
        .tick  (tick),
        .gpio  (gpio)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [LED_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pattern kept abstractly: hot-bit index for rotations, phase along the
    // bounce round trip, integer value for count mode.
    int                m_pc     = 0;
    int                m_mode_q = 0;
    int                m_k      = 0;
    int                m_ph     = 0;
    int                m_val    = 0;
    logic [GPIO_W-1:0] m_gpio   = '0;
    logic              m_tick   = 1'b0;

    function automatic logic [LED_W-1:0] model_led();
        int pos;
        if (m_mode_q == 3) return LED_W'(m_val);
        if (m_mode_q == 2) begin
            pos = (m_ph <= LED_W - 1) ? m_ph : BOUNCE_P - m_ph;
            return LED_W'(1) << pos;
        end
        return LED_W'(1) << m_k;
    endfunction

    task automatic model_reset();
        m_pc     = 0;
        m_mode_q = 0;
        m_k      = 0;
        m_ph     = 0;
        m_val    = 0;
        m_gpio   = '0;
        m_tick   = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        m_gpio = m_gpio + 1'b1;
        m_tick = 1'b0;
        if (enable) begin
            if (m_pc >= int'(div)) begin
                m_pc   = 0;
                m_tick = 1'b1;
                if (int'(mode) != m_mode_q) begin
                    m_mode_q = int'(mode);
                    m_k      = 0;
                    m_ph     = 0;
                    m_val    = 0;
                end else begin
                    case (m_mode_q)
                        0:       m_k   = (m_k + 1) % LED_W;
                        1:       m_k   = (m_k + LED_W - 1) % LED_W;
                        2:       m_ph  = (m_ph + 1) % BOUNCE_P;
                        default: m_val = (m_val + 1) % (1 << LED_W);
                    endcase
                end
                exp_q.push_back(model_led());
            end else begin
                m_pc = m_pc + 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else      model_step();
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset_led", 32'(led), 32'h1);
                check("reset_tick", 32'(tick), 32'h0);
                check("reset_gpio", 32'(gpio), 32'h0);
            end else begin
                check("tick", 32'(tick), 32'(m_tick));
                check("gpio", 32'(gpio), 32'(m_gpio));
                if (tick) begin
                    check("exp_q_has_entry", 32'(exp_q.size() != 0), 32'h1);
                    if (exp_q.size() != 0) check("led_at_tick", 32'(led), 32'(exp_q.pop_front()));
                end else begin
                    if (m_tick && exp_q.size() != 0) void'(exp_q.pop_front());
                    check("led_hold", 32'(led), 32'(model_led()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Returns the number of cycles until tick is seen, or -1 on timeout.
    task automatic wait_tick(input int max, output int n);
        n = 0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            #1;
            n++;
            if (tick) return;
        end
        n = -1;
    endtask

    task automatic restart(input logic [1:0] m, input int d);
        rst    = 1'b0;
        mode   = m;
        div    = DIV_W'(d);
        enable = 1'b1;
        cycles(2);
        rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int                n;
    logic [GPIO_W-1:0] g0;

    initial begin
        // Reset release, rotate left, div=3
        rst    = 1'b0;
        enable = 1'b1;
        div    = DIV_W'(3);
        mode   = 2'd0;
        cycles(3);
        check("reset_led_direct", 32'(led), 32'h01);
        rst = 1'b1;
        wait_tick(20, n);
        check("first_tick_latency", 32'(n), 32'd4);
        check("first_step_led", 32'(led), 32'h02);
        wait_tick(20, n);
        check("tick_period", 32'(n), 32'd4);
        check("second_step_led", 32'(led), 32'h04);
        for (int i = 0; i < 5; i++) wait_tick(20, n);
        check("rotl_top", 32'(led), 32'h80);
        wait_tick(20, n);
        check("rotl_wrap", 32'(led), 32'h01);

        // Enable gating mid-period
        cycles(2);
        g0     = gpio;
        enable = 1'b0;
        cycles(10);
        check("gpio_while_disabled", 32'(gpio - g0), 32'd10);
        check("led_frozen", 32'(led), 32'h01);
        enable = 1'b1;
        wait_tick(20, n);
        check("gating_remaining", 32'(n), 32'd2);
        check("gating_led", 32'(led), 32'h02);

        // Shrinking div below the running count
        div = DIV_W'(100);
        cycles(50);
        div = DIV_W'(5);
        wait_tick(200, n);
        check("shrink_first", 32'(n), 32'd1);
        wait_tick(200, n);
        check("shrink_period", 32'(n), 32'd6);

        // Bounce from reset, then async reset mid-run
        restart(2'd2, 0);
        wait_tick(5, n);
        check("bounce_reload_latency", 32'(n), 32'd1);
        check("bounce_reload_led", 32'(led), 32'h01);
        for (int i = 0; i < 40 && !(m_mode_q == 2 && m_ph == 9); i++) cycles(1);
        check("bounce_down_led", 32'(led), 32'h20);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_led", 32'(led), 32'h01);
        check("async_rst_tick", 32'(tick), 32'h0);
        check("async_rst_gpio", 32'(gpio), 32'h0);
        cycles(2);
        rst = 1'b1;
        wait_tick(5, n);
        check("bounce_restart_seed", 32'(led), 32'h01);
        wait_tick(5, n);
        check("bounce_restart_up", 32'(led), 32'h02);
        cycles(30);

        // Count mode, div=0, full wrap
        restart(2'd3, 0);
        wait_tick(5, n);
        check("count_reload", 32'(led), 32'h00);
        cycles(255);
        check("count_top", 32'(led), 32'hFF);
        cycles(1);
        check("count_wrap", 32'(led), 32'h00);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) div = DIV_W'($urandom_range(0, 7));
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            cycles(1);
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
- Parametrised LED pattern generator for board bring-up; successor to the fixed 8-bit rotating-LED block.
- A programmable prescaler produces step ticks. Each tick advances an LED_W-bit pattern in one of four modes: rotate left, rotate right, bounce, binary count.
- Also drives a free-running cycle counter onto the GPIO header for scope and logic-analyser checks.
- Sits at top level directly behind the board clock and reset pins.

Parameters:
- LED_W, 8, pattern/LED width; legal range is ≥1.
- DIV_W, 27, prescaler width; also the width of the div input.
- GPIO_W, 27, width of the free-running GPIO counter.

Ports:
- clk  in  1  board clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  1 = prescaler runs and pattern advances; 0 = both hold.
- div  in  DIV_W  tick period minus one; a tick occurs every div+1 enabled cycles.
- mode  in  2  0 rotate-left, 1 rotate-right, 2 bounce, 3 binary count.
- led  out  LED_W  current pattern (registered).
- tick  out  1  registered one-cycle pulse, high in the cycle the new led value first appears.
- gpio  out  GPIO_W  free-running cycle counter (registered).

Behaviour:
- Reset (rst=0, asynchronous):
  - pcount=0, led=1 (LSB only), dir=up, mode_q=0, tick=0, gpio=0.
  - Reset is honoured mid-operation on any cycle; there is no partial state on release.
- gpio:
  - increments every clk while out of reset, independent of enable.
  - wraps from all-ones to 0.
- Prescaler pcount (DIV_W bits):
  - When enable=1: if pcount>=div, then pcount<=0 and step_evt=1; else pcount<=pcount+1.
  - The >= compare means lowering div below the current pcount forces a step on the next enabled cycle (no long wrap).
  - div=0 gives a step every enabled cycle.
  - When enable=0: pcount, led, dir and mode_q hold; tick=0.
- Step (on the same edge that wraps pcount):
  - tick<=1 for exactly one cycle; otherwise tick<=0.
  - If mode != mode_q: mode_q<=mode and led<=seed, with no step applied on this tick.
    - seed is 1 for modes 0, 1 and 2; 0 for mode 3.
    - dir<=up.
  - Otherwise step according to mode_q:
    - 0: led<={led[LED_W-2:0], led[LED_W-1]}.
    - 1: led<={led[0], led[LED_W-1:1]}.
    - 2 (bounce), single hot bit:
      - If dir=up, shift left.
      - If the bit is at LED_W-1, set dir=down and shift right in the same step; the bit does not dwell at the end.
      - Symmetric at bit 0: set dir=up and shift left.
    - 3: led<=led+1 modulo 2^LED_W; all-ones wraps to 0.
  - Mode changes are therefore only applied at tick boundaries. A change that reverts before the next tick has no effect.
- LED_W=1: rotate and bounce leave led=1; count toggles 0/1.
- Latency:
  - led changes on the clock edge where pcount wraps; tick is high during the following cycle, aligned with the new led.
  - Period between ticks = div+1 enabled cycles.
- Disabling on the wrap cycle:
  - If enable falls on a cycle where pcount>=div, no step occurs and pcount holds.
  - The step fires on the first enabled cycle afterwards.

Test Plan:
- Reset release, LED_W=8, div=3, mode=0, enable=1:
  - led=0x01 and tick=0 during reset.
  - led=0x02 after the 4th edge post-release, then 0x04, 0x08; tick exactly every 4 cycles.
  - After 8 ticks led wraps 0x80->0x01.
- Bounce, div=0, mode=2 from reset:
  - The first tick only reloads (led=0x01, since mode_q was 0).
  - Then led=0x02,0x04,…,0x80,0x40,…,0x01,0x02.
  - No repeated 0x80 or 0x01 value.
- Count mode=3, div=0:
  - The first tick reloads led=0x00.
  - led=0x01…0xFF, then 0x00; tick high every cycle.
- Enable gating, div=3:
  - Drop enable for 10 cycles mid-count: led, pcount and tick frozen; gpio still advances by 10.
  - On re-enable, the remaining period completes with no extra or lost step.
- div shrink:
  - With div=100 and pcount at 50, set div=5: the step occurs on the next enabled cycle, then every 6 cycles.
- Async reset mid-run:
  - Assert rst=0 between edges in bounce mode with led=0x20, dir=down.
  - led=0x01, tick=0 and gpio=0 immediately, without waiting for a clk edge.
  - After release the pattern restarts from the seed, dir=up.
